// File: rtl/mealy_run_det_if.sv
// mealy_run_det_if: bus between the run detector and its user
//   en_i        qualifies in_i
//   in_i        serial data bit
//   mode_i      1 = overlapping detection, 0 = non-overlapping
//   out_o       Mealy detection flag
//   out_pol_o   polarity of the detected run (0 when out_o=0)
//   match_cnt_o saturating detection count
interface mealy_run_det_if #(
    parameter int CNT_W = 8
);
    logic             en_i;
    logic             in_i;
    logic             mode_i;
    logic             out_o;
    logic             out_pol_o;
    logic [CNT_W-1:0] match_cnt_o;

    modport master (output en_i, in_i, mode_i, input out_o, out_pol_o, match_cnt_o);
    modport slave  (input en_i, in_i, mode_i, output out_o, out_pol_o, match_cnt_o);
endinterface

// File: rtl/mealy_run_det.sv
// mealy_run_det: Mealy detector of RUN_LEN consecutive equal bits with a saturating hit counter
//   clk   rising-edge clock
//   Reset synchronous active-high reset
//   bus   mealy_run_det_if slave (en_i, in_i, mode_i -> out_o, out_pol_o, match_cnt_o)
module mealy_run_det #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input logic            clk,
    input logic            Reset,
    mealy_run_det_if.slave bus
);
    localparam int RW = $clog2(RUN_LEN);

    typedef enum logic [1:0] {IDLE, ZRUN, ORUN} state_t;

    state_t           state_q;
    logic [RW-1:0]    run_q;
    logic [CNT_W-1:0] cnt_q;
    logic             same;
    logic             det;

    // same: the accepted bit extends the current run
    always_comb begin
        same = (state_q == ZRUN && !bus.in_i) || (state_q == ORUN && bus.in_i);
        det  = !Reset && bus.en_i && same && run_q == RW'(RUN_LEN - 1);
    end

    assign bus.out_o       = det;
    assign bus.out_pol_o   = det & bus.in_i;
    assign bus.match_cnt_o = cnt_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            run_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (det && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
                IDLE: if (bus.en_i) begin
                    state_q <= bus.in_i ? ORUN : ZRUN;
                    run_q   <= RW'(1);
                end
                ZRUN, ORUN: if (bus.en_i) begin
                    if (!same) begin
                        state_q <= bus.in_i ? ORUN : ZRUN;
                        run_q   <= RW'(1);
                    end else if (run_q != RW'(RUN_LEN - 1)) begin
                        run_q <= run_q + RW'(1);
                    end else if (!bus.mode_i) begin
                        // non-overlapping: next hit needs a completely fresh run
                        state_q <= IDLE;
                        run_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    run_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mealy_run_det.sv
// tb_mealy_run_det: vector table, corner sequences and random run-length model check
module tb_mealy_run_det;
    localparam int RL = 4;

    typedef struct {
        logic r, e, i, m, o, p;
        int   c;
    } vec_t;

    logic clk = 1'b0;
    logic rst, en, din, md;
    int   checks = 0, errors = 0;
    vec_t tv[$];
    int   len, cnt1, cnt2;
    logic last;

    always #5 clk = ~clk;

    mealy_run_det_if #(.CNT_W(8)) b1 ();
    mealy_run_det_if #(.CNT_W(2)) b2 ();

    assign b1.en_i = en;
    assign b1.in_i = din;
    assign b1.mode_i = md;
    assign b2.en_i = en;
    assign b2.in_i = din;
    assign b2.mode_i = md;

    mealy_run_det #(.RUN_LEN(RL), .CNT_W(8)) dut1 (.clk(clk), .Reset(rst), .bus(b1.slave));
    mealy_run_det #(.RUN_LEN(RL), .CNT_W(2)) dut2 (.clk(clk), .Reset(rst), .bus(b2.slave));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, x);
        end
    endtask

    task automatic step(input logic r_, input logic e_, input logic i_, input logic m_);
        @(negedge clk);
        rst = r_;
        en  = e_;
        din = i_;
        md  = m_;
        #2;
    endtask

    function automatic void add(input logic r, e, i, m, o, p, input int c);
        vec_t v;
        v.r = r; v.e = e; v.i = i; v.m = m; v.o = o; v.p = p; v.c = c;
        tv.push_back(v);
    endfunction

    // Reference: length of the current run of equal accepted bits, unbounded;
    // a non-overlapping hit restarts the count from nothing.
    function automatic logic mdet();
        return !rst && en && len > 0 && din == last && len + 1 >= RL;
    endfunction

    task automatic mupd(input logic d);
        if (rst) begin
            len = 0; cnt1 = 0; cnt2 = 0;
        end else if (en) begin
            if (d) begin
                len  = md ? len + 1 : 0;
                cnt1 = cnt1 < 255 ? cnt1 + 1 : 255;
                cnt2 = cnt2 < 3 ? cnt2 + 1 : 3;
            end else if (len > 0 && din == last) begin
                len++;
            end else begin
                last = din;
                len  = 1;
            end
        end
    endtask

    initial begin
        logic d, bv;
        rst = 1'b1; en = 1'b0; din = 1'b0; md = 1'b0;
        // overlapping zeros
        for (int k = 0; k < 6; k++) add(0, 1, 0, 1, k >= 3, 0, k >= 3 ? k - 3 : 0);
        add(1, 1, 0, 1, 0, 0, 3);
        // non-overlapping ones
        for (int k = 0; k < 8; k++) add(0, 1, 1, 0, k == 3 || k == 7, k == 3 || k == 7, k >= 4 ? 1 : 0);
        add(1, 1, 1, 0, 0, 0, 2);
        // polarity switch restarts the run
        for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 1, 0, 0, k == 3, 0, 0);
        add(1, 1, 0, 0, 0, 0, 1);
        // en=0 holds the partial run
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 1);
        // reset mid-run discards the run
        for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(0, 1, 0, 0, k == 3, 0, 0);
        // en=0 with a bit that would complete a run
        for (int k = 0; k < 3; k++) add(0, 1, 1, 1, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 1, 1, 1);

        step(1, 1, 1, 1);
        step(1, 0, 0, 0);
        for (int k = 0; k < tv.size(); k++) begin
            step(tv[k].r, tv[k].e, tv[k].i, tv[k].m);
            chk($sformatf("tv%0d_out", k), b1.out_o, tv[k].o);
            chk($sformatf("tv%0d_pol", k), b1.out_pol_o, tv[k].p);
            chk($sformatf("tv%0d_cnt", k), b1.match_cnt_o, tv[k].c);
        end
        step(0, 0, 0, 0);
        chk("tv_final_cnt", b1.match_cnt_o, 2);

        // small counter saturation
        step(1, 1, 0, 1);
        for (int j = 0; j < 10; j++) begin
            step(0, 1, 0, 1);
            chk($sformatf("sat%0d_out", j), b2.out_o, j >= 3);
            chk($sformatf("sat%0d_pol", j), b2.out_pol_o, 0);
            chk($sformatf("sat%0d_cnt", j), b2.match_cnt_o, j <= 3 ? 0 : (j - 3 > 3 ? 3 : j - 3));
        end
        step(0, 0, 0, 1);
        chk("sat_cnt2", b2.match_cnt_o, 3);
        chk("sat_cnt1", b1.match_cnt_o, 7);

        // randomized run stimulus against the model
        step(1, 0, 0, 0);
        mupd(1'b0);
        bv = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(3) == 0) bv = ~bv;
            step($urandom_range(63) == 0, $urandom_range(3) != 0, bv,
                 $urandom_range(15) == 0 ? ~md : md);
            d = mdet();
            chk("rnd_out1", b1.out_o, d);
            chk("rnd_pol1", b1.out_pol_o, d & din);
            chk("rnd_cnt1", b1.match_cnt_o, cnt1);
            chk("rnd_out2", b2.out_o, d);
            chk("rnd_pol2", b2.out_pol_o, d & din);
            chk("rnd_cnt2", b2.match_cnt_o, cnt2);
            mupd(d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
